// File: rtl/fib_pkg.sv
// Shared types and default sizes for the Fibonacci sequencer.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OUT  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } fib_state_t;

    localparam int FIB_WIDTH      = 64;
    localparam int FIB_CNT_W      = 8;
    localparam int FIB_SETTLE_CYC = 2;

endpackage

// File: rtl/fib_sequencer_if.sv
// Control, term-stream and external-adder signals of the Fibonacci sequencer.
interface fib_sequencer_if
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH,
    parameter int CNT_W = FIB_CNT_W
);
    logic             Start;
    logic [CNT_W-1:0] NumTerms;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Term;
    logic [CNT_W-1:0] TermIndex;
    logic             TermValid;
    logic             TermReady;
    logic             Overflow;
    logic [WIDTH-1:0] AddNum1;
    logic [WIDTH-1:0] AddNum2;
    logic             AddCin;
    logic [WIDTH-1:0] AddSum;
    logic             AddCout;

    modport master (
        input  Start, NumTerms, TermReady, AddSum, AddCout,
        output Busy, Done, Term, TermIndex, TermValid, Overflow,
               AddNum1, AddNum2, AddCin
    );

    modport slave (
        output Start, NumTerms, TermReady, AddSum, AddCout,
        input  Busy, Done, Term, TermIndex, TermValid, Overflow,
               AddNum1, AddNum2, AddCin
    );
endinterface

// File: rtl/fib_settle_timer.sv
// Loadable down-counter that pulses o_expire on the last enabled clock of a
// SETTLE_CYC-long wait.
module fib_settle_timer #(
    parameter int SETTLE_CYC = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);
    localparam int CW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CW'(SETTLE_CYC);
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_expire = i_en && (r_cnt == CW'(1));
endmodule

// File: rtl/fib_sequencer.sv
// Fibonacci control FSM: holds operands A/B, drives the external adder and
// streams F(0..NumTerms-1). Define FIB_OVF_HALT_EN to stop on adder carry-out.
module fib_sequencer
    import fib_pkg::*;
#(
    parameter int WIDTH      = FIB_WIDTH,
    parameter int CNT_W      = FIB_CNT_W,
    parameter int SETTLE_CYC = FIB_SETTLE_CYC
) (
    input  logic clk,
    input  logic reset,
    fib_sequencer_if.master bus
);
    fib_state_t       r_state, w_state_next;
    logic [WIDTH-1:0] r_a, w_a_next;
    logic [WIDTH-1:0] r_b, w_b_next;
    logic [WIDTH-1:0] r_term, w_term_next;
    logic [CNT_W-1:0] r_idx, w_idx_next;
    logic [CNT_W-1:0] r_num, w_num_next;
    logic [CNT_W-1:0] w_idx_inc;
    logic             w_timer_load;
    logic             w_timer_en;
    logic             w_expire;

`ifdef FIB_OVF_HALT_EN
    logic r_ovf, w_ovf_next;
`else
    logic w_unused_cout;
    assign w_unused_cout = bus.AddCout;
`endif

    assign w_idx_inc = r_idx + CNT_W'(1);

    fib_settle_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_settle (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_timer_load),
        .i_en     (w_timer_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= WIDTH'(1);
            r_term  <= '0;
            r_idx   <= '0;
            r_num   <= '0;
`ifdef FIB_OVF_HALT_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            r_term  <= w_term_next;
            r_idx   <= w_idx_next;
            r_num   <= w_num_next;
`ifdef FIB_OVF_HALT_EN
            r_ovf   <= w_ovf_next;
`endif
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_term_next  = r_term;
        w_idx_next   = r_idx;
        w_num_next   = r_num;
        w_timer_load = 1'b0;
        w_timer_en   = 1'b0;
`ifdef FIB_OVF_HALT_EN
        w_ovf_next   = r_ovf;
`endif
        case (r_state)
            IDLE: begin
                if (bus.Start) begin
                    w_num_next   = bus.NumTerms;
                    w_idx_next   = '0;
                    w_a_next     = '0;
                    w_b_next     = WIDTH'(1);
                    w_term_next  = '0;
`ifdef FIB_OVF_HALT_EN
                    w_ovf_next   = 1'b0;
`endif
                    w_state_next = (bus.NumTerms == '0) ? DONE : OUT;
                end
            end
            OUT: begin
                if (bus.TermReady) begin
                    if (w_idx_inc == r_num) begin
                        w_state_next = DONE;
                    end else if (r_idx == '0) begin
                        // F(1) is known, so skip the adder for it
                        w_term_next = WIDTH'(1);
                        w_idx_next  = CNT_W'(1);
                    end else begin
                        w_state_next = ADD;
                        w_timer_load = 1'b1;
                    end
                end
            end
            ADD: begin
                w_timer_en = 1'b1;
                if (w_expire) begin
`ifdef FIB_OVF_HALT_EN
                    if (bus.AddCout) begin
                        w_ovf_next   = 1'b1;
                        w_state_next = DONE;
                    end else
`endif
                    begin
                        w_a_next     = r_b;
                        w_b_next     = bus.AddSum;
                        w_term_next  = bus.AddSum;
                        w_idx_next   = w_idx_inc;
                        w_state_next = OUT;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.Busy      = (r_state != IDLE);
    assign bus.Done      = (r_state == DONE);
    assign bus.TermValid = (r_state == OUT);
    assign bus.Term      = r_term;
    assign bus.TermIndex = r_idx;
    assign bus.AddNum1   = r_a;
    assign bus.AddNum2   = r_b;
    assign bus.AddCin    = 1'b0;
`ifdef FIB_OVF_HALT_EN
    assign bus.Overflow  = r_ovf;
`else
    assign bus.Overflow  = 1'b0;
`endif
endmodule
